sram_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one single-port `sram_foo` instance between NUM_PORTS requesters.
- Sits between the cache/AXI-side requesters and the SRAM macro wrapper.
- Grants at most one request per cycle and forwards it to the SRAM.
- Tracks outstanding reads and returns read data to the originating port after the SRAM read latency.

---
 rtl/sram_arb_pkg.sv | 17 +
 rtl/rr_pick.sv | 37 +++
 rtl/sram_rr_arbiter.sv | 98 +++++++++
 tb/tb_sram_rr_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for SRAM port arbiters.
package sram_arb_pkg;

  // Tag port field sized for the largest supported arbiter (8 ports).
  localparam int unsigned PW = 3;

  typedef struct packed {
    logic          valid;
    logic [PW-1:0] port;
  } read_tag_t;

  // Read latency of an sram_foo instance for a given output-register setting.
  function automatic int unsigned rl_of(input int unsigned out_regs);
    return 1 + out_regs;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Pointer-rotated priority encoder: first asserted request at or above ptr_i, wrapping at N.
module rr_pick #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic          found;
  int unsigned   cand;
  logic [IW-1:0] cand_idx;

  // Scan N candidates starting at ptr_i; wrap is explicit so non-power-of-two N works.
  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = 32'(ptr_i) + i;
      if (cand >= N) begin
        cand = cand - N;
      end
      cand_idx = IW'(cand);
      if (!found && req_i[cand_idx]) begin
        found           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NUM_PORTS requesters,
// routing read data back to the originating port after the SRAM read latency.
module sram_rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned  NUM_PORTS  = 2,
  parameter int unsigned  DATA_WIDTH = 64,
  parameter int unsigned  NUM_WORDS  = 1024,
  parameter int unsigned  OUT_REGS   = 0,
  localparam int unsigned AW         = $clog2(NUM_WORDS),
  localparam int unsigned BW         = (DATA_WIDTH + 7) / 8
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_PORTS-1:0]           req_i,
  input  logic [NUM_PORTS-1:0]           we_i,
  input  logic [NUM_PORTS*AW-1:0]        addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_i,
  input  logic [NUM_PORTS*BW-1:0]        be_i,
  output logic [NUM_PORTS-1:0]           gnt_o,
  output logic [NUM_PORTS-1:0]           rvalid_o,
  output logic [DATA_WIDTH-1:0]          rdata_o,
  output logic                           sram_req_o,
  output logic                           sram_we_o,
  output logic [AW-1:0]                  sram_addr_o,
  output logic [DATA_WIDTH-1:0]          sram_wdata_o,
  output logic [BW-1:0]                  sram_be_o,
  input  logic [DATA_WIDTH-1:0]          sram_rdata_i
);

  localparam int unsigned RL = rl_of(OUT_REGS);
  localparam int unsigned IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        win_idx;
  logic [NUM_PORTS-1:0] pick_gnt;
  logic                 any_gnt;
  read_tag_t [RL-1:0]   tag_q, tag_d;
  read_tag_t            tail;

  rr_pick #(
    .N  (NUM_PORTS),
    .IW (IW)
  ) u_pick (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (win_idx)
  );

  // Grant and forward the winner; with no request win_idx is 0 so port 0 is muxed through.
  always_comb begin
    any_gnt      = rst_ni & (|req_i);
    gnt_o        = any_gnt ? pick_gnt : '0;
    sram_req_o   = any_gnt;
    sram_we_o    = we_i[win_idx];
    sram_addr_o  = addr_i[32'(win_idx)*AW +: AW];
    sram_wdata_o = wdata_i[32'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
    sram_be_o    = be_i[32'(win_idx)*BW +: BW];
  end

  // Next pointer and read-tag shift; only granted reads enter the pipe.
  always_comb begin
    ptr_d = ptr_q;
    if (any_gnt) begin
      ptr_d = (32'(win_idx) == NUM_PORTS - 1) ? '0 : win_idx + IW'(1);
    end
    tag_d = tag_q;
    for (int unsigned s = 1; s < RL; s++) begin
      tag_d[s] = tag_q[s-1];
    end
    tag_d[0].valid = any_gnt & ~we_i[win_idx];
    tag_d[0].port  = PW'(win_idx);
  end

  // Pointer and tag pipeline state; reset discards in-flight reads.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      tag_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      tag_q <= tag_d;
    end
  end

  assign tail = tag_q[RL-1];

  // Decode the tail tag into the one-hot read-valid; data bus is shared.
  always_comb begin
    rvalid_o = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      rvalid_o[p] = tail.valid && (tail.port == PW'(p));
    end
    rdata_o = sram_rdata_i;
  end

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Bench for sram_rr_arbiter: DUT a (2 ports, RL=1), DUT b (3 ports, RL=2), each with an SRAM model.
module tb_sram_rr_arbiter;

  localparam int unsigned DW  = 64;
  localparam int unsigned BW  = 8;
  localparam int unsigned NA  = 2;
  localparam int unsigned AWA = 10;
  localparam int unsigned NB  = 3;
  localparam int unsigned AWB = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_na, rst_nb;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // DUT a
  logic [NA-1:0]     req_a, we_a, gnt_a, rvalid_a;
  logic [NA*AWA-1:0] addr_a;
  logic [NA*DW-1:0]  wdata_a;
  logic [NA*BW-1:0]  be_a;
  logic [DW-1:0]     rdata_a, sram_wdata_a, rd_a;
  logic              sram_req_a, sram_we_a;
  logic [AWA-1:0]    sram_addr_a;
  logic [BW-1:0]     sram_be_a;

  sram_rr_arbiter #(
    .NUM_PORTS  (NA),
    .DATA_WIDTH (DW),
    .NUM_WORDS  (1024),
    .OUT_REGS   (0)
  ) dut_a (
    .clk_i        (clk),
    .rst_ni       (rst_na),
    .req_i        (req_a),
    .we_i         (we_a),
    .addr_i       (addr_a),
    .wdata_i      (wdata_a),
    .be_i         (be_a),
    .gnt_o        (gnt_a),
    .rvalid_o     (rvalid_a),
    .rdata_o      (rdata_a),
    .sram_req_o   (sram_req_a),
    .sram_we_o    (sram_we_a),
    .sram_addr_o  (sram_addr_a),
    .sram_wdata_o (sram_wdata_a),
    .sram_be_o    (sram_be_a),
    .sram_rdata_i (rd_a)
  );

  // DUT b
  logic [NB-1:0]     req_b, we_b, gnt_b, rvalid_b;
  logic [NB*AWB-1:0] addr_b;
  logic [NB*DW-1:0]  wdata_b;
  logic [NB*BW-1:0]  be_b;
  logic [DW-1:0]     rdata_b, sram_wdata_b, rd_b1, rd_b2;
  logic              sram_req_b, sram_we_b;
  logic [AWB-1:0]    sram_addr_b;
  logic [BW-1:0]     sram_be_b;

  sram_rr_arbiter #(
    .NUM_PORTS  (NB),
    .DATA_WIDTH (DW),
    .NUM_WORDS  (64),
    .OUT_REGS   (1)
  ) dut_b (
    .clk_i        (clk),
    .rst_ni       (rst_nb),
    .req_i        (req_b),
    .we_i         (we_b),
    .addr_i       (addr_b),
    .wdata_i      (wdata_b),
    .be_i         (be_b),
    .gnt_o        (gnt_b),
    .rvalid_o     (rvalid_b),
    .rdata_o      (rdata_b),
    .sram_req_o   (sram_req_b),
    .sram_we_o    (sram_we_b),
    .sram_addr_o  (sram_addr_b),
    .sram_wdata_o (sram_wdata_b),
    .sram_be_o    (sram_be_b),
    .sram_rdata_i (rd_b2)
  );

  // SRAM models driven by the DUT SRAM-side ports
  logic [DW-1:0] mem_a [1024];
  logic [DW-1:0] mem_b [64];
  logic [DW-1:0] ref_a [1024];
  logic [DW-1:0] ref_b [64];

  always @(posedge clk) begin
    if (sram_req_a) begin
      if (sram_we_a) begin
        for (int b = 0; b < BW; b++) begin
          if (sram_be_a[b]) mem_a[sram_addr_a][b*8 +: 8] <= sram_wdata_a[b*8 +: 8];
        end
      end else begin
        rd_a <= mem_a[sram_addr_a];
      end
    end
  end

  always @(posedge clk) begin
    if (sram_req_b) begin
      if (sram_we_b) begin
        for (int b = 0; b < BW; b++) begin
          if (sram_be_b[b]) mem_b[sram_addr_b][b*8 +: 8] <= sram_wdata_b[b*8 +: 8];
        end
      end else begin
        rd_b1 <= mem_b[sram_addr_b];
      end
    end
    rd_b2 <= rd_b1;
  end

  // Scoreboards: expected read responses pushed at grant, popped at rvalid
  typedef struct {
    int            port;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  always @(negedge clk) begin
    if (!rst_na) begin
      qa.delete();
    end else begin
      if (rvalid_a != '0 || (qa.size() > 0 && qa[0].due == cyc)) begin
        if (qa.size() == 0) begin
          check("a_rvalid_spurious", 64'(rvalid_a), 64'd0);
        end else begin
          ea = qa.pop_front();
          check("a_rvalid_port", 64'(rvalid_a), 64'd1 << ea.port);
          check("a_rvalid_cycle", 64'(cyc), 64'(ea.due));
          check("a_rdata", rdata_a, ea.data);
        end
      end
      for (int p = 0; p < NA; p++) begin
        if (gnt_a[p]) begin
          if (we_a[p]) begin
            for (int b = 0; b < BW; b++) begin
              if (be_a[p*BW+b]) ref_a[addr_a[p*AWA +: AWA]][b*8 +: 8] = wdata_a[p*DW+b*8 +: 8];
            end
          end else begin
            qa.push_back('{p, ref_a[addr_a[p*AWA +: AWA]], cyc + 1});
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_nb) begin
      qb.delete();
    end else begin
      if (rvalid_b != '0 || (qb.size() > 0 && qb[0].due == cyc)) begin
        if (qb.size() == 0) begin
          check("b_rvalid_spurious", 64'(rvalid_b), 64'd0);
        end else begin
          eb = qb.pop_front();
          check("b_rvalid_port", 64'(rvalid_b), 64'd1 << eb.port);
          check("b_rvalid_cycle", 64'(cyc), 64'(eb.due));
          check("b_rdata", rdata_b, eb.data);
        end
      end
      for (int p = 0; p < NB; p++) begin
        if (gnt_b[p]) begin
          if (we_b[p]) begin
            for (int b = 0; b < BW; b++) begin
              if (be_b[p*BW+b]) ref_b[addr_b[p*AWB +: AWB]][b*8 +: 8] = wdata_b[p*DW+b*8 +: 8];
            end
          end else begin
            qb.push_back('{p, ref_b[addr_b[p*AWB +: AWB]], cyc + 2});
          end
        end
      end
    end
  end

  logic [NB-1:0] exp_gnt_b4 [3]  = '{3'b001, 3'b010, 3'b001};
  logic [NB-1:0] exp_rv_b4  [6]  = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b001, 3'b000};
  logic [NB-1:0] exp_gnt_b6 [4]  = '{3'b100, 3'b001, 3'b100, 3'b001};

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = '0;
      ref_a[i] = '0;
    end
    mem_a[16] = 64'hA5A5;  ref_a[16] = 64'hA5A5;
    mem_a[32] = 64'h5A5A;  ref_a[32] = 64'h5A5A;
    for (int i = 0; i < 64; i++) begin
      mem_b[i] = 64'h1000 + 64'(i);
      ref_b[i] = 64'h1000 + 64'(i);
    end
    rst_na  = 1'b0;
    rst_nb  = 1'b0;
    req_a   = '0;
    we_a    = '0;
    addr_a  = '0;
    wdata_a = '0;
    be_a    = '1;
    req_b   = '0;
    we_b    = '0;
    addr_b  = '0;
    wdata_b = '0;
    be_b    = '1;

    // Reset holds grants and read-valids low even with requests pending
    req_a  = 2'b11;
    addr_a = {10'h020, 10'h010};
    @(negedge clk);
    check("t1_gnt_in_reset", 64'(gnt_a), 64'd0);
    check("t1_rvalid_in_reset", 64'(rvalid_a), 64'd0);
    check("t1_sram_req_in_reset", 64'(sram_req_a), 64'd0);
    @(posedge clk);
    #1 rst_na = 1'b1;

    // Continuous reads from both ports alternate starting at port 0
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t2_gnt_alternate", 64'(gnt_a), (i % 2 == 0) ? 64'd1 : 64'd2);
    end
    @(posedge clk);

    // Port 1 partial write, then port 0 reads it back
    #1;
    req_a                 = 2'b10;
    we_a                  = 2'b10;
    addr_a[AWA +: AWA]    = 10'd5;
    wdata_a[DW +: DW]     = 64'hFFFF_FFFF_DEAD_BEEF;
    be_a[BW +: BW]        = 8'h0F;
    @(negedge clk);
    check("t3_wr_gnt", 64'(gnt_a), 64'd2);
    check("t3_wr_sram_we", 64'(sram_we_a), 64'd1);
    check("t3_wr_sram_be", 64'(sram_be_a), 64'h0F);
    check("t3_wr_sram_addr", 64'(sram_addr_a), 64'd5);
    @(posedge clk);
    #1;
    req_a          = 2'b01;
    we_a           = 2'b00;
    addr_a[0 +: AWA] = 10'd5;
    @(negedge clk);
    check("t3_rd_gnt", 64'(gnt_a), 64'd1);
    check("t3_no_rvalid_for_write", 64'(rvalid_a), 64'd0);
    @(posedge clk);
    #1 req_a = '0;
    @(negedge clk);
    check("t3_rd_rvalid", 64'(rvalid_a), 64'd1);
    check("t3_rd_data", rdata_a, 64'h0000_0000_DEAD_BEEF);
    repeat (2) @(negedge clk);

    // DUT b, RL=2: reads granted 0,1,0 return 001,010,001 two cycles later
    @(posedge clk);
    #1;
    rst_nb               = 1'b1;
    req_b                = 3'b011;
    addr_b[0 +: AWB]     = 6'd3;
    addr_b[AWB +: AWB]   = 6'd7;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k < 3) check("t4_gnt", 64'(gnt_b), 64'(exp_gnt_b4[k]));
      check("t4_rvalid_pattern", 64'(rvalid_b), 64'(exp_rv_b4[k]));
      if (k == 2) begin
        @(posedge clk);
        #1 req_b = '0;
      end
    end

    // Reset one cycle after a read grant drops the in-flight read and the pointer
    @(posedge clk);
    #1 req_b = 3'b001;
    @(negedge clk);
    check("t5_pre_gnt", 64'(gnt_b), 64'd1);
    @(posedge clk);
    #1;
    rst_nb = 1'b0;
    req_b  = 3'b011;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("t5_rvalid_in_reset", 64'(rvalid_b), 64'd0);
      check("t5_gnt_in_reset", 64'(gnt_b), 64'd0);
    end
    @(posedge clk);
    #1 rst_nb = 1'b1;
    @(negedge clk);
    check("t5_no_rvalid_after", 64'(rvalid_b), 64'd0);
    check("t5_ptr_reset", 64'(gnt_b), 64'd1);

    // Three ports, only 0 and 2 requesting: pointer wraps 2 -> 0, port 1 never granted
    @(posedge clk);
    #1;
    req_b                  = 3'b101;
    addr_b[0 +: AWB]       = 6'd10;
    addr_b[2*AWB +: AWB]   = 6'd20;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t6_gnt_wrap", 64'(gnt_b), 64'(exp_gnt_b6[k]));
    end
    @(posedge clk);
    #1 req_b = '0;

    repeat (5) @(negedge clk);
    check("a_scoreboard_drained", 64'(qa.size()), 64'd0);
    check("b_scoreboard_drained", 64'(qb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
